// File: rtl/dpram_fwft_fifo_pkg.sv
// Shared defaults for the first-word-fall-through FIFO.
// The instantiating level overrides these values through parameters.
package dpram_fwft_fifo_pkg;
  localparam int DEF_DEPTH_WIDTH = 4;
  localparam int DEF_DATA_WIDTH  = 32;
endpackage

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with one write port and one read port.
// Bypass returns the write data when a write and a read hit the same address.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  bypass_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= din;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    din_q    <= din;
    bypass_q <= we && re && (waddr == raddr);
  end

  assign dout = ((ENABLE_BYPASS != 0) && bypass_q) ? din_q : rdata_q;

endmodule

// File: rtl/dpram_fwft_fifo.sv
// First-word-fall-through FIFO controller around a bypassed dual-port RAM.
// The head location is re-read every cycle so rd_data tracks the head.
module dpram_fwft_fifo
  import dpram_fwft_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   empty,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = DEPTH_WIDTH + 1;
  localparam logic [PW-1:0] CAP = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          push, pop;

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign full  = (count == CAP);

  assign push = !rst && wr_en && (!full || rd_en);
  assign pop  = !rst && rd_en && !empty;

  assign overflow  = !rst && wr_en && full && !rd_en;
  assign underflow = !rst && rd_en && empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Reading the post-pop address keeps the next head ready with no bubble.
  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH    (DEPTH_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1)
  ) u_ram (
    .clk   (clk),
    .raddr (rptr_d[DEPTH_WIDTH-1:0]),
    .re    (1'b1),
    .waddr (wptr_q[DEPTH_WIDTH-1:0]),
    .we    (push),
    .din   (wr_data),
    .dout  (rd_data)
  );

endmodule

// File: tb/tb_dpram_fwft_fifo.sv
// Directed and random stimulus for dpram_fwft_fifo at capacity 4.
// A queue model predicts occupancy, flags, pulses and head data.
module tb_dpram_fwft_fifo;

  localparam int DW  = 2;
  localparam int W   = 32;
  localparam int CAP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         full;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         empty;
  logic [DW:0]  count;
  logic         overflow;
  logic         underflow;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  dpram_fwft_fifo #(
    .DEPTH_WIDTH (DW),
    .DATA_WIDTH  (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs before the edge, then advance the model.
  task automatic step(input logic r, input logic we, input logic [W-1:0] wd,
                      input logic re);
    int n;
    logic push_ok, pop_ok;
    rst = r; wr_en = we; wr_data = wd; rd_en = re;
    #1;
    n = q.size();
    chk("count", W'(count), W'(n));
    chk("empty", W'(empty), W'(n == 0));
    chk("full", W'(full), W'(n == CAP));
    chk("overflow", W'(overflow), W'(!r && we && n == CAP && !re));
    chk("underflow", W'(underflow), W'(!r && re && n == 0));
    if (n > 0) chk("rd_data", rd_data, q[0]);
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      pop_ok  = re && n > 0;
      push_ok = we && (n < CAP || re);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(wd);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, '0, 1'b0);
    idle();

    step(1'b0, 1'b1, 32'hA1, 1'b0);
    idle();
    chk("push1_rd", rd_data, 32'hA1);
    step(1'b0, 1'b0, '0, 1'b1);
    idle();

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h10 + i, 1'b0);
    chk("full_flag", W'(full), W'(1));
    step(1'b0, 1'b1, 32'h14, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", rd_data, 32'h10 + i);
      step(1'b0, 1'b0, '0, 1'b1);
    end
    idle();

    for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, W'(i), i > 1);
    step(1'b0, 1'b0, '0, 1'b1);
    idle();

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h20 + i, 1'b0);
    step(1'b0, 1'b1, 32'h55, 1'b1);
    chk("full_pushpop_cnt", W'(count), W'(4));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    idle();

    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h77, 1'b1);
    chk("empty_pushpop_rd", rd_data, 32'h77);
    step(1'b0, 1'b0, '0, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h30 + i, 1'b0);
    step(1'b1, 1'b1, 32'hDEAD, 1'b1);
    chk("rst_empty", W'(empty), W'(1));
    step(1'b0, 1'b1, 32'h99, 1'b0);
    chk("post_rst_rd", rd_data, 32'h99);
    step(1'b0, 1'b0, '0, 1'b1);
    idle();

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, $urandom, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    end

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 1) == 1);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
